test_mode_ctrl: RTL and testbench
=================================

// Module: test_mode_ctrl
// PURPOSE
//  Sits directly upstream of TESTING_MODE and produces its TEST_sig select.
//  Test mode is entered only after a keyed arm write plus a stable, debounced request pin.
//  Entry and exit pass through guard intervals, so the output mux never switches while a functional strobe is in flight.
//  An optional watchdog forces exit if test mode is left on.
// PARAMETERS
//  CLK_1_MHz   120         clk_120 cycles per microsecond (us_tick prescaler)
//  DEB_US      10          request debounce time, us
//  GUARD_US    2           guard time in ENTER and EXIT, us
//  ARM_WIN_US  1000        window after a valid key write in which the request must arrive, us
//  WDOG_US     1000000     maximum ACTIVE time, us (only used with TEST_WDOG_EN)
//  ARM_KEY     8'hA5       arm key value
// PORTS
//  clk_120     in   1   system clock
//  reset_n     in   1   asynchronous, active-low reset
//  test_req    in   1   asynchronous test-request pin; synchronised internally with 2 FFs
//  key_wr      in   1   one-clock strobe: key_data is valid
//  key_data    in   8   arm key written by MPI
//  abort       in   1   synchronous functional override; high forces exit from test mode
//  TEST_sig    out  1   registered select to TESTING_MODE (1 = test patterns)
//  test_state  out  3   current FSM state, for status readback
//  key_err     out  1   one-clock pulse on a wrong key write
//  wdog_fault  out  1   high while in FAULT
//  sess_cnt    out  8   completed entries to ACTIVE; saturates at 255
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, all counters 0. Reset asserted mid-session drops TEST_sig asynchronously.
//  - us_tick: prescaler counts 0..CLK_1_MHz-1 and pulses us_tick for 1 clk at the wrap; it free-runs from reset.
//  - deb_req:
//    - Follows the synchronised request only after DEB_US consecutive us_ticks at the new level.
//    - Any bounce restarts the count.
//    - Initial value 0.
//  - Timer: single shared us counter, cleared on every state change.
//  - IDLE
//    - key_wr with key_data==ARM_KEY -> ARMED.
//    - key_wr with a wrong key -> key_err pulse; stay in IDLE.
//  - ARMED
//    - deb_req==1 -> ENTER.
//    - Timer reaches ARM_WIN_US -> IDLE.
//    - key_wr with a wrong key -> IDLE plus key_err.
//    - key_wr with the correct key restarts the timer.
//  - ENTER
//    - deb_req==0 or abort -> IDLE.
//    - Timer reaches GUARD_US -> ACTIVE; TEST_sig rises on the same edge; sess_cnt increments (saturating).
//  - ACTIVE (TEST_sig=1)
//    - deb_req==0 or abort -> EXIT; TEST_sig falls on the same edge.
//    - key_wr is ignored.
//  - EXIT (TEST_sig=0): timer reaches GUARD_US -> IDLE. Re-arming is required for the next session.
//  - FAULT (TEST_sig=0, wdog_fault=1): leave to IDLE only when deb_req==0.
//  - Priority in ACTIVE: abort > deb_req low > watchdog.
//    - Abort and timeout in the same cycle -> EXIT with no fault.
//  - TEST_sig is driven only from its own flop (never decoded from state), so it cannot glitch.
//  - test_state encoding: IDLE=0, ARMED=1, ENTER=2, ACTIVE=3, EXIT=4, FAULT=5.
// CONFIGURATION
//  TEST_WDOG_EN defined
//    - Timer in ACTIVE reaching WDOG_US -> FAULT; TEST_sig falls on the same edge.
//  TEST_WDOG_EN undefined
//    - No timeout; FAULT is unreachable; wdog_fault is tied to 0.
//    - The timer is sized only for max(ARM_WIN_US, GUARD_US).
// STRUCTURE
//  test_mode_pkg
//    - typedef enum logic[2:0] tm_state_t.
//    - localparam ARM_KEY_DEF.
//    - Function clog2-based timer width helper.
//  Sub-module sig_debounce (inputs: clk_120, reset_n, us_tick, din; output: dout; parameter DEB_US).
//    - Contains the 2-FF synchroniser; reusable for other pins.
// TESTING  (override: CLK_1_MHz=4, DEB_US=3, GUARD_US=2, ARM_WIN_US=50, WDOG_US=200)
//  1. Normal session
//     - Stimulus: key 8'hA5, raise test_req.
//     - Required: TEST_sig=1 at 12 clk (debounce) + 8 clk (guard) after the sync delay, ±1 us_tick; sess_cnt=1.
//     - Stimulus: drop test_req.
//     - Required: TEST_sig=0 after debounce; IDLE 8 clk later.
//  2. Wrong key
//     - Stimulus: write 8'h5A, then raise test_req.
//     - Required: one key_err pulse; state stays IDLE; TEST_sig stays 0.
//  3. Arm window
//     - Stimulus: write 8'hA5; no request for 50 us.
//     - Required: state returns to IDLE; a later request does not enter test mode.
//  4. Bounce
//     - Stimulus: test_req toggles every 2 us while ARMED.
//     - Required: deb_req never changes; no ENTER.
//  5. Abort
//     - Stimulus: abort pulse in ACTIVE.
//     - Required: TEST_sig=0 on the next edge, then EXIT -> IDLE.
//     - Stimulus: abort during ENTER.
//     - Required: state goes to IDLE; sess_cnt unchanged.
//  6. Watchdog, TEST_WDOG_EN defined
//     - Stimulus: hold ACTIVE for 200 us.
//     - Required: FAULT; wdog_fault=1; TEST_sig=0.
//     - Stimulus: release test_req.
//     - Required: state returns to IDLE.
//  6. Watchdog, TEST_WDOG_EN undefined
//     - Stimulus: hold ACTIVE for 200 us.
//     - Required: TEST_sig stays 1.

Source files
------------

// File: rtl/test_mode_pkg.sv
// Shared types and sizing helpers for the test-mode entry controller.
package test_mode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ENTER  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_EXIT   = 3'd4,
        ST_FAULT  = 3'd5
    } tm_state_t;

    localparam logic [7:0] ARM_KEY_DEF = 8'hA5;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int tmr_width(input int max_val);
        return (max_val < 32'sd1) ? 32'sd1 : $clog2(max_val + 32'sd1);
    endfunction

    // Largest value the shared timer must reach; the watchdog limit counts only when built in.
    function automatic int tmr_max(input int arm_us, input int guard_us,
                                   input int wdog_us, input bit wdog_en);
        int m;
        m = (arm_us > guard_us) ? arm_us : guard_us;
        if (wdog_en && (wdog_us > m)) begin
            m = wdog_us;
        end
        return m;
    endfunction

endpackage

// File: rtl/sig_debounce.sv
// Two-flop synchroniser followed by a microsecond-based debouncer for a slow control pin.
module sig_debounce
    import test_mode_pkg::*;
#(
    parameter int DEB_US = 10
) (
    input  logic clk_120,
    input  logic reset_n,
    input  logic us_tick,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = tmr_width(DEB_US);

    logic             sync1_r;
    logic             sync2_r;
    logic             dout_r;
    logic [CNT_W-1:0] cnt_r;

    // Metastability synchroniser for the asynchronous pin.
    always_ff @(posedge clk_120 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Output moves only after DEB_US consecutive ticks at the new level; any bounce restarts.
    always_ff @(posedge clk_120 or negedge reset_n) begin
        if (!reset_n) begin
            dout_r <= 1'b0;
            cnt_r  <= '0;
        end else if (sync2_r == dout_r) begin
            cnt_r <= '0;
        end else if (us_tick) begin
            if (cnt_r >= CNT_W'(DEB_US - 1)) begin
                dout_r <= sync2_r;
                cnt_r  <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/test_mode_ctrl.sv
// Keyed, debounced, guard-interval test-mode entry controller driving TEST_sig.
// Optional ACTIVE-time watchdog is built in when TEST_WDOG_EN is defined.
module test_mode_ctrl
    import test_mode_pkg::*;
#(
    parameter int         CLK_1_MHz  = 120,
    parameter int         DEB_US     = 10,
    parameter int         GUARD_US   = 2,
    parameter int         ARM_WIN_US = 1000,
    parameter int         WDOG_US    = 1000000,
    parameter logic [7:0] ARM_KEY    = ARM_KEY_DEF
) (
    input  logic       clk_120,
    input  logic       reset_n,
    input  logic       test_req,
    input  logic       key_wr,
    input  logic [7:0] key_data,
    input  logic       abort,
    output logic       TEST_sig,
    output logic [2:0] test_state,
    output logic       key_err,
    output logic       wdog_fault,
    output logic [7:0] sess_cnt
);

`ifdef TEST_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif
    localparam int TMR_MAX = tmr_max(ARM_WIN_US, GUARD_US, WDOG_US, WDOG_EN);
    localparam int TMR_W   = tmr_width(TMR_MAX);
    localparam int PRE_W   = tmr_width(CLK_1_MHz - 1);

    logic [PRE_W-1:0] presc_r;
    logic             us_tick_s;
    logic             deb_req_s;
    logic             key_ok_s;
    tm_state_t        state_r;
    logic [TMR_W-1:0] timer_r;
    logic             test_sig_r;
    logic             key_err_r;
    logic [7:0]       sess_cnt_r;
`ifdef TEST_WDOG_EN
    logic             wdog_fault_r;
`endif

    // Free-running microsecond prescaler.
    always_ff @(posedge clk_120 or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= '0;
        end else if (presc_r == PRE_W'(CLK_1_MHz - 1)) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    assign us_tick_s = (presc_r == PRE_W'(CLK_1_MHz - 1));
    assign key_ok_s  = (key_data == ARM_KEY);

    sig_debounce #(
        .DEB_US (DEB_US)
    ) u_req_deb (
        .clk_120 (clk_120),
        .reset_n (reset_n),
        .us_tick (us_tick_s),
        .din     (test_req),
        .dout    (deb_req_s)
    );

    // Session FSM; the timer is cleared on every transition (later assignment wins).
    always_ff @(posedge clk_120 or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            timer_r      <= '0;
            test_sig_r   <= 1'b0;
            key_err_r    <= 1'b0;
            sess_cnt_r   <= 8'd0;
`ifdef TEST_WDOG_EN
            wdog_fault_r <= 1'b0;
`endif
        end else begin
            key_err_r <= 1'b0;
            if (us_tick_s && (timer_r != TMR_W'(TMR_MAX))) begin
                timer_r <= timer_r + TMR_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (key_wr && key_ok_s) begin
                        state_r <= ST_ARMED;
                        timer_r <= '0;
                    end else if (key_wr) begin
                        key_err_r <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (key_wr && !key_ok_s) begin
                        state_r   <= ST_IDLE;
                        timer_r   <= '0;
                        key_err_r <= 1'b1;
                    end else if (deb_req_s) begin
                        state_r <= ST_ENTER;
                        timer_r <= '0;
                    end else if (key_wr) begin
                        timer_r <= '0;
                    end else if (timer_r >= TMR_W'(ARM_WIN_US)) begin
                        state_r <= ST_IDLE;
                        timer_r <= '0;
                    end
                end
                ST_ENTER: begin
                    if (abort || !deb_req_s) begin
                        state_r <= ST_IDLE;
                        timer_r <= '0;
                    end else if (timer_r >= TMR_W'(GUARD_US)) begin
                        state_r    <= ST_ACTIVE;
                        timer_r    <= '0;
                        test_sig_r <= 1'b1;
                        if (sess_cnt_r != 8'hFF) begin
                            sess_cnt_r <= sess_cnt_r + 8'd1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Abort and request loss outrank the watchdog, so a coincident timeout is not a fault.
                    if (abort || !deb_req_s) begin
                        state_r    <= ST_EXIT;
                        timer_r    <= '0;
                        test_sig_r <= 1'b0;
                    end
`ifdef TEST_WDOG_EN
                    else if (timer_r >= TMR_W'(WDOG_US)) begin
                        state_r      <= ST_FAULT;
                        timer_r      <= '0;
                        test_sig_r   <= 1'b0;
                        wdog_fault_r <= 1'b1;
                    end
`endif
                end
                ST_EXIT: begin
                    if (timer_r >= TMR_W'(GUARD_US)) begin
                        state_r <= ST_IDLE;
                        timer_r <= '0;
                    end
                end
                ST_FAULT: begin
                    if (!deb_req_s) begin
                        state_r      <= ST_IDLE;
                        timer_r      <= '0;
`ifdef TEST_WDOG_EN
                        wdog_fault_r <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    timer_r    <= '0;
                    test_sig_r <= 1'b0;
                end
            endcase
        end
    end

    assign TEST_sig   = test_sig_r;
    assign test_state = state_r;
    assign key_err    = key_err_r;
    assign sess_cnt   = sess_cnt_r;
`ifdef TEST_WDOG_EN
    assign wdog_fault = wdog_fault_r;
`else
    assign wdog_fault = 1'b0;
`endif

endmodule

// File: tb/tb_test_mode_ctrl.sv
// Self-checking bench for test_mode_ctrl with scaled timing; honours TEST_WDOG_EN like the design.
module tb_test_mode_ctrl;

    localparam int CLK   = 4;
    localparam int DEB   = 3;
    localparam int GUARD = 2;
    localparam int ARMW  = 50;
    localparam int WDOG  = 200;
    localparam logic [7:0] KEY = 8'hA5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_ENTER  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_EXIT   = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic       clk_120 = 1'b0;
    logic       reset_n;
    logic       test_req;
    logic       key_wr;
    logic [7:0] key_data;
    logic       abort;
    logic       TEST_sig;
    logic [2:0] test_state;
    logic       key_err;
    logic       wdog_fault;
    logic [7:0] sess_cnt;

    int checks = 0;
    int errors = 0;
    int exp_sess = 0;
    int kerr_cnt = 0;

    test_mode_ctrl #(
        .CLK_1_MHz (CLK),
        .DEB_US    (DEB),
        .GUARD_US  (GUARD),
        .ARM_WIN_US(ARMW),
        .WDOG_US   (WDOG),
        .ARM_KEY   (KEY)
    ) dut (
        .clk_120   (clk_120),
        .reset_n   (reset_n),
        .test_req  (test_req),
        .key_wr    (key_wr),
        .key_data  (key_data),
        .abort     (abort),
        .TEST_sig  (TEST_sig),
        .test_state(test_state),
        .key_err   (key_err),
        .wdog_fault(wdog_fault),
        .sess_cnt  (sess_cnt)
    );

    always #5 clk_120 = ~clk_120;

    // Counts cycles during which key_err was high (value held before each rising edge).
    always @(posedge clk_120) begin
        if (key_err === 1'b1) kerr_cnt <= kerr_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_120);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_120);
            if (test_state === s) begin
                cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic wait_sig(input logic v, input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_120);
            if (TEST_sig === v) begin
                cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic write_key(input logic [7:0] k);
        key_data = k;
        key_wr   = 1'b1;
        @(negedge clk_120);
        key_wr   = 1'b0;
    endtask

    function automatic logic [7:0] wrong_key();
        logic [7:0] k;
        k = 8'($urandom_range(0, 255));
        if (k == KEY) k = ~k;
        return k;
    endfunction

    task automatic settle();
        int c;
        test_req = 1'b0;
        abort    = 1'b0;
        key_wr   = 1'b0;
        step((DEB + GUARD + 4) * CLK);
        wait_state(S_IDLE, (ARMW + 4) * CLK, c);
        checks++;
        if (c < 0) begin errors++; $display("FAIL settle_idle: state %0d, wanted %0d", test_state, S_IDLE); end
    endtask

    // Key then request; expects TEST_sig within debounce + guard (+ 2 sync clocks) +/- one us.
    task automatic enter_session(input string tag);
        int c;
        write_key(KEY);
        checks++;
        if (test_state !== S_ARMED) begin errors++; $display("FAIL %s_armed: state %0d, wanted %0d", tag, test_state, S_ARMED); end
        test_req = 1'b1;
        wait_sig(1'b1, 2 + (DEB + GUARD + 3) * CLK, c);
        if (exp_sess < 255) exp_sess++;
        checks++;
        if (c < 2 + (DEB + GUARD - 1) * CLK || c > 2 + (DEB + GUARD + 1) * CLK) begin
            errors++; $display("FAIL %s_entry_latency: %0d clk, wanted %0d..%0d", tag, c,
                               2 + (DEB + GUARD - 1) * CLK, 2 + (DEB + GUARD + 1) * CLK);
        end
        checks++;
        if (sess_cnt !== 8'(exp_sess)) begin errors++; $display("FAIL %s_sess_cnt: %0d, wanted %0d", tag, sess_cnt, exp_sess); end
    endtask

    // Drop the request; TEST_sig falls after debounce, IDLE one guard later.
    task automatic leave_session(input string tag);
        int c;
        test_req = 1'b0;
        wait_sig(1'b0, 2 + (DEB + 3) * CLK, c);
        checks++;
        if (c < 2 + (DEB - 1) * CLK || c > 2 + (DEB + 1) * CLK + 1) begin
            errors++; $display("FAIL %s_exit_latency: %0d clk, wanted %0d..%0d", tag, c,
                               2 + (DEB - 1) * CLK, 2 + (DEB + 1) * CLK + 1);
        end
        checks++;
        if (test_state !== S_EXIT) begin errors++; $display("FAIL %s_exit_state: %0d, wanted %0d", tag, test_state, S_EXIT); end
        wait_state(S_IDLE, (GUARD + 3) * CLK, c);
        checks++;
        if (c < (GUARD - 1) * CLK + 1 || c > (GUARD + 1) * CLK) begin
            errors++; $display("FAIL %s_exit_guard: %0d clk, wanted %0d..%0d", tag, c, (GUARD - 1) * CLK + 1, (GUARD + 1) * CLK);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; test_req = 1'b0; key_wr = 1'b0; key_data = 8'h00; abort = 1'b0;
        step(3);
        checks++;
        if ({TEST_sig, key_err, wdog_fault} !== 3'b000) begin errors++; $display("FAIL reset_flags: %b, wanted 000", {TEST_sig, key_err, wdog_fault}); end
        checks++;
        if (test_state !== S_IDLE) begin errors++; $display("FAIL reset_state: %0d, wanted %0d", test_state, S_IDLE); end
        checks++;
        if (sess_cnt !== 8'd0) begin errors++; $display("FAIL reset_sess: %0d, wanted 0", sess_cnt); end
        reset_n = 1'b1;
        step(2);
    endtask

    task automatic test_normal();
        enter_session("normal");
        checks++;
        if (test_state !== S_ACTIVE) begin errors++; $display("FAIL normal_active: %0d, wanted %0d", test_state, S_ACTIVE); end
        step(10);
        leave_session("normal");
        settle();
    endtask

    task automatic test_wrong_key();
        int k0;
        k0 = kerr_cnt;
        write_key(wrong_key());
        checks++;
        if (key_err !== 1'b1) begin errors++; $display("FAIL wrongkey_pulse: %b, wanted 1", key_err); end
        step(1);
        checks++;
        if (key_err !== 1'b0) begin errors++; $display("FAIL wrongkey_pulse_end: %b, wanted 0", key_err); end
        test_req = 1'b1;
        step((DEB + GUARD + 4) * CLK);
        checks++;
        if (test_state !== S_IDLE || TEST_sig !== 1'b0) begin
            errors++; $display("FAIL wrongkey_no_entry: state %0d sig %b, wanted %0d 0", test_state, TEST_sig, S_IDLE);
        end
        checks++;
        if (kerr_cnt !== k0 + 1) begin errors++; $display("FAIL wrongkey_count: %0d pulses, wanted 1", kerr_cnt - k0); end
        settle();
    endtask

    task automatic test_arm_window();
        int c;
        write_key(KEY);
        wait_state(S_IDLE, (ARMW + 3) * CLK, c);
        checks++;
        if (c < (ARMW - 1) * CLK || c > (ARMW + 1) * CLK) begin
            errors++; $display("FAIL armwin_timeout: %0d clk, wanted %0d..%0d", c, (ARMW - 1) * CLK, (ARMW + 1) * CLK);
        end
        test_req = 1'b1;
        step((DEB + GUARD + 4) * CLK);
        checks++;
        if (test_state !== S_IDLE || TEST_sig !== 1'b0) begin
            errors++; $display("FAIL armwin_late_req: state %0d sig %b, wanted %0d 0", test_state, TEST_sig, S_IDLE);
        end
        settle();
    endtask

    task automatic test_bounce();
        int bad;
        int n;
        bad = 0;
        n = $urandom_range(4, 7);
        write_key(KEY);
        for (int t = 0; t < n; t++) begin
            test_req = 1'b1;
            for (int i = $urandom_range(CLK, 2 * CLK); i > 0; i--) begin
                @(negedge clk_120);
                if (test_state !== S_ARMED || TEST_sig !== 1'b0) bad++;
            end
            test_req = 1'b0;
            for (int i = $urandom_range(1, 2 * CLK); i > 0; i--) begin
                @(negedge clk_120);
                if (test_state !== S_ARMED || TEST_sig !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bounce_stay_armed: %0d bad cycles, wanted 0", bad); end
        settle();
    endtask

    task automatic test_abort();
        int c;
        int s0;
        enter_session("abort");
        step($urandom_range(0, 10));
        abort = 1'b1;
        @(negedge clk_120);
        abort = 1'b0;
        checks++;
        if (TEST_sig !== 1'b0 || test_state !== S_EXIT) begin
            errors++; $display("FAIL abort_active: sig %b state %0d, wanted 0 %0d", TEST_sig, test_state, S_EXIT);
        end
        wait_state(S_IDLE, (GUARD + 3) * CLK, c);
        checks++;
        if (c < (GUARD - 1) * CLK + 1 || c > (GUARD + 1) * CLK) begin
            errors++; $display("FAIL abort_guard: %0d clk, wanted %0d..%0d", c, (GUARD - 1) * CLK + 1, (GUARD + 1) * CLK);
        end
        // Request is still debounced high, so re-arming goes straight to ENTER.
        s0 = exp_sess;
        write_key(KEY);
        step(1);
        checks++;
        if (test_state !== S_ENTER) begin errors++; $display("FAIL abort_reach_enter: %0d, wanted %0d", test_state, S_ENTER); end
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++;
        if (test_state !== S_IDLE || TEST_sig !== 1'b0 || sess_cnt !== 8'(s0)) begin
            errors++; $display("FAIL abort_enter: state %0d sig %b sess %0d, wanted %0d 0 %0d", test_state, TEST_sig, sess_cnt, S_IDLE, s0);
        end
        settle();
    endtask

    task automatic test_watchdog();
        int c;
        enter_session("wdog");
`ifdef TEST_WDOG_EN
        wait_state(S_FAULT, (WDOG + 4) * CLK, c);
        checks++;
        if (c < (WDOG - 1) * CLK || c > (WDOG + 1) * CLK + 2) begin
            errors++; $display("FAIL wdog_timeout: %0d clk, wanted %0d..%0d", c, (WDOG - 1) * CLK, (WDOG + 1) * CLK + 2);
        end
        checks++;
        if (wdog_fault !== 1'b1 || TEST_sig !== 1'b0) begin
            errors++; $display("FAIL wdog_fault_out: fault %b sig %b, wanted 1 0", wdog_fault, TEST_sig);
        end
        step(20);
        checks++;
        if (test_state !== S_FAULT) begin errors++; $display("FAIL wdog_hold_fault: %0d, wanted %0d", test_state, S_FAULT); end
        test_req = 1'b0;
        wait_state(S_IDLE, 2 + (DEB + 3) * CLK, c);
        checks++;
        if (c < 0 || wdog_fault !== 1'b0) begin
            errors++; $display("FAIL wdog_release: state %0d fault %b, wanted %0d 0", test_state, wdog_fault, S_IDLE);
        end
`else
        c = 0;
        for (int i = 0; i < (WDOG + 50) * CLK; i++) begin
            @(negedge clk_120);
            if (TEST_sig !== 1'b1 || wdog_fault !== 1'b0) c++;
        end
        checks++;
        if (c != 0) begin errors++; $display("FAIL nowdog_hold: %0d bad cycles, wanted 0", c); end
        leave_session("nowdog");
`endif
        settle();
    endtask

    task automatic test_random();
        int k0;
        int r;
        for (int it = 0; it < 10; it++) begin
            k0 = kerr_cnt;
            r = $urandom_range(0, 2);
            if (r == 0) begin
                write_key(wrong_key());
                step(1);
                checks++;
                if (kerr_cnt !== k0 + 1 || test_state !== S_IDLE) begin
                    errors++; $display("FAIL rnd_idle_wrong: pulses %0d state %0d, wanted 1 %0d", kerr_cnt - k0, test_state, S_IDLE);
                end
            end else if (r == 1) begin
                write_key(KEY);
                step($urandom_range(1, 20));
                write_key(wrong_key());
                step(1);
                checks++;
                if (kerr_cnt !== k0 + 1 || test_state !== S_IDLE) begin
                    errors++; $display("FAIL rnd_armed_wrong: pulses %0d state %0d, wanted 1 %0d", kerr_cnt - k0, test_state, S_IDLE);
                end
            end else begin
                enter_session("rnd");
                for (int i = $urandom_range(0, 40); i > 0; i--) begin
                    if ($urandom_range(0, 3) == 0) write_key(8'($urandom_range(0, 255)));
                    else step(1);
                end
                step(1);
                checks++;
                if (kerr_cnt !== k0 || test_state !== S_ACTIVE) begin
                    errors++; $display("FAIL rnd_active_keys: pulses %0d state %0d, wanted 0 %0d", kerr_cnt - k0, test_state, S_ACTIVE);
                end
                leave_session("rnd");
            end
            settle();
        end
    endtask

    task automatic test_saturation();
        int c;
        for (int s = 0; s < 260; s++) begin
            write_key(KEY);
            test_req = 1'b1;
            wait_sig(1'b1, 2 + (DEB + GUARD + 3) * CLK, c);
            if (exp_sess < 255) exp_sess++;
            checks++;
            if (c < 0) begin errors++; $display("FAIL sat_entry_%0d: timeout, wanted TEST_sig 1", s); end
            test_req = 1'b0;
            wait_state(S_IDLE, 2 + (DEB + GUARD + 4) * CLK, c);
            checks++;
            if (c < 0) begin errors++; $display("FAIL sat_exit_%0d: timeout, state %0d", s, test_state); end
        end
        checks++;
        if (sess_cnt !== 8'(exp_sess)) begin errors++; $display("FAIL sat_value: %0d, wanted %0d", sess_cnt, exp_sess); end
    endtask

    task automatic test_reset_mid();
        enter_session("midrst");
        step(3);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (TEST_sig !== 1'b0) begin errors++; $display("FAIL midrst_async_drop: %b, wanted 0", TEST_sig); end
        exp_sess = 0;
        checks++;
        if (test_state !== S_IDLE || sess_cnt !== 8'd0) begin
            errors++; $display("FAIL midrst_clear: state %0d sess %0d, wanted %0d 0", test_state, sess_cnt, S_IDLE);
        end
        test_req = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);
        enter_session("postrst");
        leave_session("postrst");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_wrong_key();
        test_arm_window();
        test_bounce();
        test_abort();
        test_watchdog();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
